// File: rtl/ysyx_22051145_fetch_queue.sv
// ysyx_22051145_fetch_queue: fetch stage issuing one instruction read at a time into a {pc,inst} FIFO for decode
// Optional same-cycle response bypass to decode when FETCH_QUEUE_BYPASS_EN is defined.
module ysyx_22051145_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT_RSP = 2'd1, DROP = 2'd2;
  logic [1:0]        r_state;
  logic [1:0]        w_state_n;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [PW:0]       r_count;
  logic [ADDR_W-1:0] r_pc_q [DEPTH];
  logic [INST_W-1:0] r_inst_q [DEPTH];
  logic              w_rsp, w_byp, w_push, w_pop, w_nempty;
  assign w_nempty      = r_count != '0;
  assign mem_req_valid = (r_state == IDLE) & pc_valid & ~flush & (r_count < FULL) & ~rst;
  assign mem_req_addr  = pc_in;
  assign pc_ready      = mem_req_valid & mem_req_ready;
  assign w_rsp         = (r_state == WAIT_RSP) & mem_rsp_valid & ~flush;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_rsp & ~w_nempty & id_ready;
`else
  assign w_byp = 1'b0;
`endif
  assign w_push   = w_rsp & ~w_byp;
  assign w_pop    = w_nempty & ~flush & id_ready;
  assign id_valid = (w_nempty | w_byp) & ~flush;
  assign id_pc    = w_byp ? r_pend_pc : r_pc_q[r_rd_ptr];
  assign id_inst  = w_byp ? mem_rsp_data : r_inst_q[r_rd_ptr];
  // A response that arrives together with a flush is dropped without a detour through DROP.
  assign w_state_n = (r_state == IDLE)     ? (pc_ready ? WAIT_RSP : IDLE) :
                     (r_state == WAIT_RSP) ? (mem_rsp_valid ? IDLE : flush ? DROP : WAIT_RSP) :
                     (r_state == DROP)     ? (mem_rsp_valid ? IDLE : DROP) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pend_pc <= '0;
    end else begin
      r_state <= w_state_n;
      if (pc_ready) r_pend_pc <= pc_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]   <= r_pend_pc;
      r_inst_q[r_wr_ptr] <= mem_rsp_data;
    end
  end
endmodule

// File: tb/tb_ysyx_22051145_fetch_queue.sv
// tb_ysyx_22051145_fetch_queue: directed cycle table plus full, flush-in-flight and wrap sequences
module tb_ysyx_22051145_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, pc_valid, pc_ready, flush;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic        id_valid, id_ready;
  logic [63:0] pc_in, mem_req_addr, id_pc;
  logic [31:0] mem_rsp_data, id_inst;
  int n_chk = 0, n_err = 0;

  ysyx_22051145_fetch_queue dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, pv; logic [63:0] pc; logic fl, rr, rv; logic [31:0] rd; logic ir;
    logic e_rv, e_pr, e_iv; logic [63:0] e_pc; logic [31:0] e_in;
  } vec_t;

  function automatic vec_t mk(logic r, logic pv, logic [63:0] pc, logic fl, logic rr, logic rv,
                              logic [31:0] rd, logic ir, logic erv, logic epr, logic eiv,
                              logic [63:0] epc, logic [31:0] ein);
    vec_t v;
    v.rst = r; v.pv = pv; v.pc = pc; v.fl = fl; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
    v.e_rv = erv; v.e_pr = epr; v.e_iv = eiv; v.e_pc = epc; v.e_in = ein;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic pv, input logic [63:0] pc, input logic fl,
                       input logic rr, input logic rv, input logic [31:0] rd, input logic ir);
    rst = r; pc_valid = pv; pc_in = pc; flush = fl;
    mem_req_ready = rr; mem_rsp_valid = rv; mem_rsp_data = rd; id_ready = ir;
  endtask

  vec_t v[21];
  logic [95:0] q[$];

  initial begin
    v[0]  = mk(1, 1, 64'h80000000, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    v[1]  = mk(1, 1, 64'h80000000, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    v[2]  = mk(0, 1, 64'h80000000, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    v[3]  = mk(0, 1, 64'h80000004, 0, 1, 1, 32'h00000013, 1, 0, 0, 0, 0, 0);
    v[4]  = mk(0, 1, 64'h80000004, 0, 1, 0, 0, 1, 1, 1, 1, 64'h80000000, 32'h00000013);
    v[5]  = mk(0, 1, 64'h80000008, 0, 1, 1, 32'h00100093, 1, 0, 0, 0, 0, 0);
    v[6]  = mk(0, 1, 64'h80000008, 0, 1, 0, 0, 1, 1, 1, 1, 64'h80000004, 32'h00100093);
    v[7]  = mk(0, 0, 0, 0, 1, 1, 32'h00200113, 1, 0, 0, 0, 0, 0);
    v[8]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 64'h80000008, 32'h00200113);
    v[9]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    v[10] = mk(0, 1, 64'h80000100, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    v[11] = mk(0, 1, 64'h80000104, 0, 1, 1, 32'h11111111, 0, 0, 0, 0, 0, 0);
    v[12] = mk(0, 1, 64'h80000104, 0, 1, 0, 0, 0, 1, 1, 1, 64'h80000100, 32'h11111111);
    v[13] = mk(0, 1, 64'h80000108, 0, 1, 1, 32'h22222222, 0, 0, 0, 1, 64'h80000100, 32'h11111111);
    v[14] = mk(0, 1, 64'h80000108, 0, 1, 0, 0, 0, 1, 1, 1, 64'h80000100, 32'h11111111);
    v[15] = mk(0, 1, 64'h80000108, 1, 1, 1, 32'h33333333, 0, 0, 0, 0, 0, 0);
    v[16] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    v[17] = mk(0, 1, 64'h80000200, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    v[18] = mk(0, 0, 0, 0, 1, 1, 32'h44444444, 1, 0, 0, 0, 0, 0);
    v[19] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 64'h80000200, 32'h44444444);
    v[20] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);

    drive(1, 1, 64'h80000000, 0, 1, 0, 0, 1);
    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      drive(v[i].rst, v[i].pv, v[i].pc, v[i].fl, v[i].rr, v[i].rv, v[i].rd, v[i].ir);
      #1;
      chk($sformatf("row%0d mem_req_valid", i), 64'(mem_req_valid), 64'(v[i].e_rv));
      chk($sformatf("row%0d pc_ready", i), 64'(pc_ready), 64'(v[i].e_pr));
      chk($sformatf("row%0d id_valid", i), 64'(id_valid), 64'(v[i].e_iv));
      if (v[i].e_rv) chk($sformatf("row%0d mem_req_addr", i), mem_req_addr, v[i].pc);
      if (v[i].e_iv) begin
        chk($sformatf("row%0d id_pc", i), id_pc, v[i].e_pc);
        chk($sformatf("row%0d id_inst", i), 64'(id_inst), 64'(v[i].e_in));
      end
      @(negedge clk);
    end

    // flush while a request is outstanding: DROP swallows the late response
    drive(0, 1, 64'h80000010, 0, 1, 0, 0, 1); #1;
    chk("flt handshake", 64'(pc_ready), 64'd1);
    @(negedge clk);
    drive(0, 1, 64'h80000020, 1, 1, 0, 0, 1); #1;
    chk("flt flush req", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    drive(0, 1, 64'h80000020, 0, 1, 0, 0, 1); #1;
    chk("flt drop req", 64'(mem_req_valid), 64'd0);
    chk("flt drop idv", 64'(id_valid), 64'd0);
    @(negedge clk);
    drive(0, 1, 64'h80000020, 0, 1, 1, 32'hdeadbeef, 1); #1;
    chk("flt rsp req", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    drive(0, 1, 64'h80000020, 0, 1, 0, 0, 1); #1;
    chk("flt after idv", 64'(id_valid), 64'd0);
    chk("flt new req", 64'(mem_req_valid), 64'd1);
    chk("flt new addr", mem_req_addr, 64'h80000020);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 32'h00000055, 1); #1;
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0, 1); #1;
    chk("flt out idv", 64'(id_valid), 64'd1);
    chk("flt out pc", id_pc, 64'h80000020);
    chk("flt out inst", 64'(id_inst), 64'h55);
    @(negedge clk);

    // fill all four entries, then one pop reopens issue
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 64'h80001000 + 64'(4 * i), 0, 1, 0, 0, 0); #1;
      chk($sformatf("full hs%0d", i), 64'(pc_ready), 64'd1);
      @(negedge clk);
      drive(0, 1, 64'h80001000 + 64'(4 * i + 4), 0, 1, 1, 32'hA0 + 32'(i), 0); #1;
      @(negedge clk);
    end
    drive(0, 1, 64'h80001010, 0, 1, 0, 0, 0); #1;
    chk("full req", 64'(mem_req_valid), 64'd0);
    chk("full idv", 64'(id_valid), 64'd1);
    chk("full head", id_pc, 64'h80001000);
    @(negedge clk);
    drive(0, 1, 64'h80001010, 0, 1, 0, 0, 1); #1;
    chk("full pop req", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    drive(0, 1, 64'h80001010, 0, 1, 0, 0, 0); #1;
    chk("full reissue", 64'(pc_ready), 64'd1);
    chk("full reissue addr", mem_req_addr, 64'h80001010);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 32'hA4, 0); #1;
    @(negedge clk);
    for (int j = 1; j <= 4; j++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 1); #1;
      chk($sformatf("drain%0d idv", j), 64'(id_valid), 64'd1);
      chk($sformatf("drain%0d pc", j), id_pc, 64'h80001000 + 64'(4 * j));
      chk($sformatf("drain%0d inst", j), 64'(id_inst), 64'hA0 + 64'(j));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 1); #1;
    chk("drain empty", 64'(id_valid), 64'd0);
    @(negedge clk);

    // ten entries through the ring with random backpressure on both sides
    begin
      int issued = 0, got = 0, cyc = 0;
      logic pend = 1'b0;
      logic [63:0] pend_pc = '0;
      logic [31:0] pend_inst;
      logic [95:0] e;
      while (got < 10 && cyc < 400) begin
        pend_inst = pend_pc[31:0] ^ 32'h5a5a0000;
        drive(0, issued < 10, 64'h80002000 + 64'(4 * issued), 0, 1'($urandom_range(0, 1)),
              pend, pend ? pend_inst : 32'h0, 1'($urandom_range(0, 1)));
        #1;
        chk("wrap idv", 64'(id_valid), 64'(q.size() != 0));
        if (id_valid && id_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("wrap pc", id_pc, e[95:32]);
          chk("wrap inst", 64'(id_inst), 64'(e[31:0]));
          got++;
        end
        if (pend) q.push_back({pend_pc, pend_inst});
        pend = pc_ready;
        if (pc_ready) begin
          pend_pc = pc_in;
          issued++;
        end
        cyc++;
        @(negedge clk);
      end
      chk("wrap received", 64'(got), 64'd10);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
